// File: rtl/render_pixel_collector.sv
`default_nettype none
// ============================================================================
// Module   : render_pixel_collector
// Purpose  : Requests pixel bursts from the Mandelbrot engine, palette-maps
//            them and streams them into a linear frame-buffer write port.
// Revision : 1.0 - initial release
// ============================================================================
module render_pixel_collector #(
  parameter int set_size       = 1,
  parameter int max_iterations = 255,
  parameter int HBI            = 32,
  parameter int fifo_depth     = 16
) (
  input  logic           CLK,
  input  logic           SYS_RESET,
  input  logic           ready,
  input  logic [HBI-1:0] data,
  input  logic           frame_ready,
  input  logic [20:0]    total_pixels,
  input  logic [7:0]     color_offset,
  output logic           send_data,
  output logic           clear_frame,
  output logic           fb_we,
  output logic [20:0]    fb_addr,
  output logic [7:0]     fb_wdata,
  input  logic           fb_ready,
  output logic           frame_done
);

  localparam int c_AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int c_WW = (set_size > 1) ? $clog2(set_size) : 1;

  localparam logic [c_AW:0]    c_DEPTH     = (c_AW+1)'(fifo_depth);
  localparam logic [c_AW:0]    c_SET       = (c_AW+1)'(set_size);
  localparam logic [c_WW-1:0]  c_LAST_WORD = c_WW'(set_size - 1);
  localparam logic [HBI-1:0]   c_MAX_IT    = HBI'(max_iterations);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_CAPT = 2'd2;
  localparam logic [1:0] c_ST_HOLD = 2'd3;

  logic [1:0]      r_state;
  logic [c_WW-1:0] r_word;
  logic            r_hold;
  logic            r_send_data;
  logic            r_clear_frame;
  logic            r_fr_latched;
  logic            r_fb_we;
  logic [20:0]     r_fb_addr;
  logic [7:0]      r_fb_wdata;
  logic            r_frame_done;
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic [7:0]      r_mem [fifo_depth];

  logic            w_push;
  logic            w_pop;
  logic [c_AW:0]   w_free;
  logic [c_AW:0]   w_remain;
  logic [c_AW-1:0] w_head_ptr;
  logic [7:0]      w_color;
  logic            w_last_pix;

  assign w_push     = (r_state == c_ST_CAPT);
  assign w_pop      = r_fb_we & fb_ready;
  assign w_free     = c_DEPTH - r_count;
  assign w_color    = (data >= c_MAX_IT) ? 8'h00 : (data[7:0] + color_offset);
  // Occupancy and head after this cycle's pop, ignoring this cycle's push:
  // a freshly captured word only becomes visible one cycle later.
  assign w_remain   = r_count - (c_AW+1)'(w_pop);
  assign w_head_ptr = r_rptr + c_AW'(w_pop);
  assign w_last_pix = (r_fb_addr == (total_pixels - 21'd1));

  assign send_data   = r_send_data;
  assign clear_frame = r_clear_frame;
  assign fb_we       = r_fb_we;
  assign fb_addr     = r_fb_addr;
  assign fb_wdata    = r_fb_wdata;
  assign frame_done  = r_frame_done;

  // HOLD gives the engine two idle cycles before the next request.
  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_state     <= c_ST_IDLE;
      r_word      <= '0;
      r_hold      <= 1'b0;
      r_send_data <= 1'b0;
    end else begin
      r_send_data <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (ready && (w_free >= c_SET)) begin
            r_send_data <= 1'b1;
            r_state     <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          r_word  <= '0;
          r_state <= c_ST_CAPT;
        end
        c_ST_CAPT: begin
          if (r_word == c_LAST_WORD) begin
            r_hold  <= 1'b0;
            r_state <= c_ST_HOLD;
          end else begin
            r_word <= r_word + 1'b1;
          end
        end
        c_ST_HOLD: begin
          if (r_hold) begin
            r_state <= c_ST_IDLE;
          end else begin
            r_hold <= 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_color;
    end
  end

  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_fb_we      <= 1'b0;
      r_fb_addr    <= '0;
      r_fb_wdata   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_fb_we      <= (w_remain != '0);
      r_frame_done <= w_pop & w_last_pix;
      if (w_remain != '0) begin
        r_fb_wdata <= r_mem[w_head_ptr];
      end
      if (w_pop) begin
        r_fb_addr <= w_last_pix ? 21'd0 : (r_fb_addr + 21'd1);
      end
    end
  end

  always_ff @(posedge CLK or posedge SYS_RESET) begin
    if (SYS_RESET) begin
      r_clear_frame <= 1'b0;
      r_fr_latched  <= 1'b0;
    end else begin
      r_clear_frame <= 1'b0;
      if (frame_ready && !r_clear_frame && !r_fr_latched) begin
        r_clear_frame <= 1'b1;
        r_fr_latched  <= 1'b1;
      end else if (!frame_ready) begin
        r_fr_latched <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_render_pixel_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_render_pixel_collector
// Purpose  : Directed self-checking bench with an engine responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_render_pixel_collector;

  localparam int c_SET = 4;

  logic        CLK = 1'b0;
  logic        SYS_RESET;
  logic        ready;
  logic [31:0] data;
  logic        frame_ready;
  logic [20:0] total_pixels;
  logic [7:0]  color_offset;
  logic        send_data;
  logic        clear_frame;
  logic        fb_we;
  logic [20:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_ready;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int nsend = 0;
  int ncf   = 0;
  int nfd   = 0;
  int fd_at = -1;
  int base;
  logic [28:0] wr_q [$];
  logic [31:0] eng_q [$];
  logic [7:0]  t2_exp [4];

  render_pixel_collector #(
    .set_size(c_SET), .max_iterations(255), .HBI(32), .fifo_depth(16)
  ) u_dut (
    .CLK(CLK), .SYS_RESET(SYS_RESET), .ready(ready), .data(data),
    .frame_ready(frame_ready), .total_pixels(total_pixels),
    .color_offset(color_offset), .send_data(send_data),
    .clear_frame(clear_frame), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .fb_ready(fb_ready), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  // Observed write log and pulse counters
  always @(posedge CLK) begin
    if (send_data === 1'b1)   nsend <= nsend + 1;
    if (clear_frame === 1'b1) ncf <= ncf + 1;
    if (frame_done === 1'b1) begin
      nfd   <= nfd + 1;
      fd_at <= wr_q.size();
    end
    if (fb_we === 1'b1 && fb_ready === 1'b1) wr_q.push_back({fb_addr, fb_wdata});
  end

  // Engine: after a request, present one word per cycle from the second edge on
  always begin
    @(posedge CLK); #1;
    if (send_data === 1'b1 && !SYS_RESET) begin
      for (int i = 0; i < c_SET; i++) begin
        @(posedge CLK); #1;
        if (SYS_RESET) break;
        data = (eng_q.size() > 0) ? eng_q.pop_front() : 32'd0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic load4(input logic [31:0] a, b, c, d);
    eng_q.push_back(a); eng_q.push_back(b); eng_q.push_back(c); eng_q.push_back(d);
  endtask

  task automatic wait_send(input int target, input string tag);
    int k = 0;
    while (nsend < target && k < 60) begin
      tick();
      k++;
    end
    chk(tag, 32'(nsend >= target), 32'd1);
  endtask

  initial begin
    SYS_RESET = 1'b1; ready = 1'b0; data = '0; frame_ready = 1'b0;
    total_pixels = 21'd100; color_offset = 8'd0; fb_ready = 1'b1;
    tick(3);
    chk("rst_send", 32'(send_data), 32'd0);
    chk("rst_clear", 32'(clear_frame), 32'd0);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_wdata", 32'(fb_wdata), 32'd0);
    SYS_RESET = 1'b0;
    tick(2);
    chk("idle_no_send", 32'(send_data), 32'd0);

    // Single burst, cycle-exact latency, offset 0
    load4(32'd37, 32'd100, 32'd254, 32'd255);
    ready = 1'b1;
    tick();
    chk("t1_send_hi", 32'(send_data), 32'd1);
    tick();
    chk("t1_send_lo", 32'(send_data), 32'd0);
    ready = 1'b0;
    tick();
    chk("t1_we_latency", 32'(fb_we), 32'd0);
    tick();
    chk("t1_we", 32'(fb_we), 32'd1);
    chk("t1_wdata0", 32'(fb_wdata), 32'd37);
    chk("t1_addr0", 32'(fb_addr), 32'd0);
    tick();
    chk("t1_wdata1", {3'b0, fb_addr, fb_wdata}, {3'b0, 21'd1, 8'd100});
    tick();
    chk("t1_wdata2", {3'b0, fb_addr, fb_wdata}, {3'b0, 21'd2, 8'd254});
    tick();
    chk("t1_wdata3", {3'b0, fb_addr, fb_wdata}, {3'b0, 21'd3, 8'd0});
    tick();
    chk("t1_we_off", 32'(fb_we), 32'd0);
    chk("t1_addr_end", 32'(fb_addr), 32'd4);
    chk("t1_nsend", 32'(nsend), 32'd1);

    // Colour map with offset and saturation compare on the full word
    color_offset = 8'd5;
    wr_q.delete();
    load4(32'd10, 32'd255, 32'd300, 32'd0);
    t2_exp = '{8'd15, 8'd0, 8'd0, 8'd5};
    ready = 1'b1;
    wait_send(2, "t2_req");
    ready = 1'b0;
    tick(12);
    chk("t2_count", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_wr%0d", i), 32'(wr_q[i]), {3'b0, 21'(4 + i), t2_exp[i]});

    // Backpressure: FIFO fills after four bursts, then requests stop
    fb_ready = 1'b0;
    wr_q.delete();
    for (int i = 0; i < 16; i++) eng_q.push_back(32'(i * 7));
    base = nsend;
    ready = 1'b1;
    tick(40);
    chk("t3_bursts", 32'(nsend - base), 32'd4);
    chk("t3_we_held", 32'(fb_we), 32'd1);
    chk("t3_addr_held", 32'(fb_addr), 32'd8);
    chk("t3_head", 32'(fb_wdata), 32'd5);
    chk("t3_no_write", 32'(wr_q.size()), 32'd0);
    ready = 1'b0;
    fb_ready = 1'b1;
    tick(25);
    chk("t3_count", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_wr%0d", i), 32'(wr_q[i]), {3'b0, 21'(8 + i), 8'(i * 7 + 5)});

    // Reset in the middle of a burst, after the first word is captured
    wr_q.delete();
    load4(32'd1, 32'd2, 32'd3, 32'd4);
    ready = 1'b1;
    tick();
    chk("t6_send", 32'(send_data), 32'd1);
    ready = 1'b0;
    tick(2);
    SYS_RESET = 1'b1;
    #1;
    chk("t6_rst_we", 32'(fb_we), 32'd0);
    chk("t6_rst_addr", 32'(fb_addr), 32'd0);
    chk("t6_rst_wdata", 32'(fb_wdata), 32'd0);
    chk("t6_rst_send", 32'(send_data), 32'd0);
    tick(2);
    eng_q.delete();
    total_pixels = 21'd6;
    color_offset = 8'd0;
    SYS_RESET = 1'b0;
    tick(10);
    chk("t6_no_write", 32'(wr_q.size()), 32'd0);
    chk("t6_we_idle", 32'(fb_we), 32'd0);

    // Frame wrap at total_pixels = 6 across two bursts
    for (int i = 0; i < 8; i++) eng_q.push_back(32'(50 + i));
    base = nfd;
    ready = 1'b1;
    wait_send(nsend + 2, "t4_req");
    ready = 1'b0;
    tick(15);
    chk("t4_count", 32'(wr_q.size()), 32'd8);
    chk("t4_fd_pulses", 32'(nfd - base), 32'd1);
    chk("t4_fd_after", 32'(fd_at), 32'd6);
    chk("t4_wr0", 32'(wr_q[0]), {3'b0, 21'd0, 8'd50});
    chk("t4_wr5", 32'(wr_q[5]), {3'b0, 21'd5, 8'd55});
    chk("t4_wr6", 32'(wr_q[6]), {3'b0, 21'd0, 8'd56});
    chk("t4_wr7", 32'(wr_q[7]), {3'b0, 21'd1, 8'd57});

    // Frame handshake
    base = ncf;
    frame_ready = 1'b1;
    tick();
    chk("t5_cf_hi", 32'(clear_frame), 32'd1);
    tick();
    chk("t5_cf_lo", 32'(clear_frame), 32'd0);
    tick(8);
    chk("t5_one_pulse", 32'(ncf - base), 32'd1);
    frame_ready = 1'b0;
    tick(2);
    frame_ready = 1'b1;
    tick(3);
    chk("t5_second", 32'(ncf - base), 32'd2);
    frame_ready = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
